// File: rtl/dma16_bus_master.sv
// dma16_bus_master: block-copy DMA that borrows the CPU16 memory bus via hold/busy.
// Define DMA16_FILL_EN to add the constant-fill mode (fill input).

module dma16_bus_master #(
   parameter int RAM_WAIT = 1,
   parameter int DATA_W   = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [15:0]       src_addr,
   input  logic [15:0]       dst_addr,
   input  logic [15:0]       count,
`ifdef DMA16_FILL_EN
   input  logic              fill,
`endif
   output logic              hold,
   input  logic              busy,
   output logic              bus_grant,
   output logic [15:0]       address,
   input  logic [DATA_W-1:0] data_in,
   output logic [DATA_W-1:0] data_out,
   output logic              write,
   output logic              active,
   output logic              done
);

   localparam int WW = (RAM_WAIT > 0) ? $clog2(RAM_WAIT + 1) : 1;
   localparam logic [WW-1:0] WAIT_LAST = WW'(RAM_WAIT);

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_READ,
      S_WRITE,
      S_NEXT,
      S_DONE
   } state_t;

   state_t            state_q;
   logic [15:0]       src_q;
   logic [15:0]       dst_q;
   logic [15:0]       cnt_q;
   logic [15:0]       src_d;
   logic [15:0]       dst_d;
   logic [15:0]       cnt_d;
   logic [WW-1:0]     wait_q;
   logic [DATA_W-1:0] word_q;
   logic [15:0]       addr_q;
   logic              hold_q;
   logic              grant_q;
   logic              write_q;
   logic              active_q;
   logic              done_q;
   logic              fill_q;

`ifndef DMA16_FILL_EN
   assign fill_q = 1'b0;
`endif

   // In fill mode the source register holds the constant, so it never advances.
   always_comb begin
      src_d = fill_q ? src_q : src_q + 16'd1;
      dst_d = dst_q + 16'd1;
      cnt_d = cnt_q - 16'd1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= S_IDLE;
         src_q    <= '0;
         dst_q    <= '0;
         cnt_q    <= '0;
         wait_q   <= '0;
         word_q   <= '0;
         addr_q   <= '0;
         hold_q   <= 1'b0;
         grant_q  <= 1'b0;
         write_q  <= 1'b0;
         active_q <= 1'b0;
         done_q   <= 1'b0;
`ifdef DMA16_FILL_EN
         fill_q   <= 1'b0;
`endif
      end else begin
         unique case (state_q)
            S_IDLE, S_DONE: begin
               done_q  <= 1'b0;
               state_q <= S_IDLE;
               if (start) begin
                  if (count != 16'd0) begin
                     src_q    <= src_addr;
                     dst_q    <= dst_addr;
                     cnt_q    <= count;
`ifdef DMA16_FILL_EN
                     fill_q   <= fill;
`endif
                     active_q <= 1'b1;
                     hold_q   <= 1'b1;
                     state_q  <= S_REQ;
                  end else begin
                     done_q <= 1'b1;
                  end
               end
            end
            S_REQ: begin
               if (busy) begin
                  grant_q <= 1'b1;
                  wait_q  <= '0;
                  if (fill_q) begin
                     addr_q  <= dst_q;
                     word_q  <= DATA_W'(src_q);
                     write_q <= 1'b1;
                     state_q <= S_WRITE;
                  end else begin
                     addr_q  <= src_q;
                     state_q <= S_READ;
                  end
               end
            end
            S_READ: begin
               if (wait_q == WAIT_LAST) begin
                  word_q  <= data_in;
                  addr_q  <= dst_q;
                  write_q <= 1'b1;
                  state_q <= S_WRITE;
               end else begin
                  wait_q <= wait_q + WW'(1);
               end
            end
            S_WRITE: begin
               write_q <= 1'b0;
               src_q   <= src_d;
               dst_q   <= dst_d;
               cnt_q   <= cnt_d;
               state_q <= S_NEXT;
            end
            S_NEXT: begin
               wait_q <= '0;
               if (cnt_q == 16'd0) begin
                  hold_q   <= 1'b0;
                  grant_q  <= 1'b0;
                  active_q <= 1'b0;
                  done_q   <= 1'b1;
                  state_q  <= S_DONE;
               end else if (fill_q) begin
                  addr_q  <= dst_q;
                  word_q  <= DATA_W'(src_q);
                  write_q <= 1'b1;
                  state_q <= S_WRITE;
               end else begin
                  addr_q  <= src_q;
                  state_q <= S_READ;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign hold      = hold_q;
   assign bus_grant = grant_q;
   assign address   = addr_q;
   assign data_out  = word_q;
   assign write     = write_q;
   assign active    = active_q;
   assign done      = done_q;

endmodule

// File: tb/tb_dma16_bus_master.sv
// tb_dma16_bus_master: random and directed transfers against a word-array
// memory model; expected writes/reads/done are queued and checked by a monitor.

module tb_dma16_bus_master;

   localparam int RW = 1;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [15:0] src_addr;
   logic [15:0] dst_addr;
   logic [15:0] count;
   logic        hold;
   logic        busy;
   logic        bus_grant;
   logic [15:0] address;
   logic [15:0] data_in;
   logic [15:0] data_out;
   logic        write;
   logic        active;
   logic        done;
`ifdef DMA16_FILL_EN
   logic        fill;
`endif

   always #5 clk = ~clk;

   dma16_bus_master #(.RAM_WAIT(RW), .DATA_W(16)) dut (
      .clk(clk),
      .reset(reset),
      .start(start),
      .src_addr(src_addr),
      .dst_addr(dst_addr),
      .count(count),
`ifdef DMA16_FILL_EN
      .fill(fill),
`endif
      .hold(hold),
      .busy(busy),
      .bus_grant(bus_grant),
      .address(address),
      .data_in(data_in),
      .data_out(data_out),
      .write(write),
      .active(active),
      .done(done)
   );

   logic [15:0] ram  [0:65535];
   logic [15:0] refm [0:65535];

   int tests = 0;
   int fails = 0;
   int busy_delay = 2;

   typedef struct {
      logic [15:0] a;
      logic [15:0] d;
      int          gap;
   } wr_t;

   wr_t         wq[$];
   logic [15:0] rdq[$];
   int          dq[$];

   // registered RAM: one cycle of read latency
   always @(posedge clk) data_in <= ram[address];

   initial forever begin
      @(posedge clk);
      if (write && bus_grant) ram[address] = data_out;
   end

   task automatic chk(input string nm, input logic [31:0] got,
                      input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h need %0h", nm, got, exp);
      end
   endtask

   // CPU16 stand-in: parks busy_delay cycles after hold rises
   initial begin
      int hc;
      busy = 1'b0;
      hc = 0;
      forever begin
         @(posedge clk);
         #1;
         if (!hold) begin
            busy = 1'b0;
            hc = 0;
         end else if (!busy) begin
            if (hc >= busy_delay) busy = 1'b1;
            else hc++;
         end
      end
   end

   initial begin
      int cyc, lw, ls, de;
      logic ph, pb, pg, pw;
      wr_t e;
      logic [15:0] ra;
      cyc = 0; lw = 0; ls = 0;
      ph = 0; pb = 0; pg = 0; pw = 0;
      forever begin
         @(negedge clk);
         cyc++;
         if (start) ls = cyc;
         if (ph && pb && !pg) chk("grant_after_busy", bus_grant, 1);
         if (ph && !pb && !pg) chk("no_grant_before_busy", bus_grant, 0);
         if (write) begin
            chk("write_has_grant", bus_grant, 1);
            if (wq.size() == 0) begin
               chk("unexpected_write", 1, 0);
            end else begin
               e = wq.pop_front();
               chk("wr_addr", address, e.a);
               chk("wr_data", data_out, e.d);
               if (e.gap != 0) chk("wr_gap", cyc - lw, e.gap);
            end
            lw = cyc;
         end
         if (bus_grant && !write && !pw) begin
            if (rdq.size() == 0) begin
               chk("unexpected_read", address, 0);
               chk("unexpected_read_cnt", 1, 0);
            end else begin
               ra = rdq.pop_front();
               chk("rd_addr", address, ra);
            end
         end
         if (done) begin
            chk("done_not_active", {hold, bus_grant, write, active}, 0);
            if (dq.size() == 0) begin
               chk("unexpected_done", 1, 0);
            end else begin
               de = dq.pop_front();
               if (de == 0) chk("done_gap_start", cyc - ls, 1);
               else chk("done_gap_write", cyc - lw, 2);
            end
         end
         ph = hold; pb = busy; pg = bus_grant; pw = write;
      end
   end

   task automatic load(input logic [15:0] a, input logic [15:0] v);
      ram[a] = v;
      refm[a] = v;
   endtask

   task automatic prep(input logic [15:0] s, input logic [15:0] d,
                       input int n);
      logic [15:0] a;
      a = s;
      for (int i = 0; i < n; i++) begin
         load(a, 16'($urandom));
         a++;
      end
      a = d;
      for (int i = 0; i < n; i++) begin
         load(a, 16'($urandom));
         a++;
      end
   endtask

   // reference: ascending word-at-a-time copy with 16-bit pointer wrap
   task automatic push_copy(input logic [15:0] s, input logic [15:0] d,
                            input int n);
      logic [15:0] v;
      for (int i = 0; i < n; i++) begin
         for (int k = 0; k <= RW; k++) rdq.push_back(s);
         v = refm[s];
         refm[d] = v;
         wq.push_back('{d, v, (i == 0) ? 0 : 3 + RW});
         s++;
         d++;
      end
      dq.push_back(1);
   endtask

   task automatic push_fill(input logic [15:0] s, input logic [15:0] d,
                            input int n);
      for (int i = 0; i < n; i++) begin
         refm[d] = s;
         wq.push_back('{d, s, (i == 0) ? 0 : 2});
         d++;
      end
      dq.push_back(1);
   endtask

   task automatic start_xfer(input logic [15:0] s, input logic [15:0] d,
                             input logic [15:0] n, input logic f);
      @(posedge clk);
      #1;
      src_addr = s;
      dst_addr = d;
      count = n;
`ifdef DMA16_FILL_EN
      fill = f;
`else
      if (f) chk("fill_unsupported", 1, 0);
`endif
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic wait_done();
      for (int k = 0; k < 500; k++) begin
         @(negedge clk);
         if (done) return;
      end
      chk("done_timeout", 0, 1);
   endtask

   task automatic check_mem(input logic [15:0] d, input int n);
      logic [15:0] a;
      int bad;
      a = d;
      bad = 0;
      for (int i = 0; i < n; i++) begin
         if (ram[a] !== refm[a]) bad++;
         a++;
      end
      chk("mem_dst", bad, 0);
   endtask

   task automatic end_checks();
      chk("wq_empty", wq.size(), 0);
      chk("rdq_empty", rdq.size(), 0);
      chk("dq_empty", dq.size(), 0);
   endtask

   initial begin
      logic [15:0] s, d, a;
      int n, bad, wc;
      logic f;
      reset = 1'b1;
      start = 1'b0;
      src_addr = '0;
      dst_addr = '0;
      count = '0;
`ifdef DMA16_FILL_EN
      fill = 1'b0;
`endif
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ctrl", {hold, bus_grant, write, active, done}, 0);
      chk("rst_addr", address, 0);
      chk("rst_dout", data_out, 0);
      @(negedge clk);
      reset = 1'b0;

      // directed copy
      for (int i = 0; i < 4; i++) begin
         load(16'(16'h0100 + i), 16'(16'h1111 * (i + 1)));
         load(16'(16'h0200 + i), 16'h0000);
      end
      busy_delay = 2;
      push_copy(16'h0100, 16'h0200, 4);
      start_xfer(16'h0100, 16'h0200, 4, 1'b0);
      wait_done();
      repeat (2) @(negedge clk);
      for (int i = 0; i < 4; i++)
         chk("copy_word", ram[16'(16'h0200 + i)], 16'(16'h1111 * (i + 1)));
      end_checks();

      // CPU slow to park
      busy_delay = 20;
      prep(16'h1000, 16'h1100, 2);
      push_copy(16'h1000, 16'h1100, 2);
      start_xfer(16'h1000, 16'h1100, 2, 1'b0);
      chk("hs_hold", hold, 1);
      bad = 0;
      repeat (20) begin
         @(negedge clk);
         if (bus_grant || write) bad++;
      end
      chk("hs_parked", bad, 0);
      wait_done();
      repeat (2) @(negedge clk);
      check_mem(16'h1100, 2);
      end_checks();

      // zero count
      busy_delay = 1;
      dq.push_back(0);
      start_xfer(16'h1234, 16'h4321, 0, 1'b0);
      wait_done();
      chk("zero_quiet", {hold, active, write}, 0);
      bad = 0;
      repeat (3) begin
         @(negedge clk);
         if (hold || active || write || done) bad++;
      end
      chk("zero_after", bad, 0);
      end_checks();

      // pointer wrap
      load(16'hFFFE, 16'hA001);
      load(16'hFFFF, 16'hA002);
      load(16'h0000, 16'hA003);
      for (int i = 0; i < 3; i++) load(16'(16'h7FFF + i), 16'h0);
      push_copy(16'hFFFE, 16'h7FFF, 3);
      start_xfer(16'hFFFE, 16'h7FFF, 3, 1'b0);
      wait_done();
      repeat (2) @(negedge clk);
      chk("wrap_7fff", ram[16'h7FFF], 16'hA001);
      chk("wrap_8000", ram[16'h8000], 16'hA002);
      chk("wrap_8001", ram[16'h8001], 16'hA003);
      end_checks();

      // reset during the second write
      for (int i = 0; i < 5; i++) begin
         load(16'(16'h0400 + i), 16'($urandom) & 16'h7FFF);
         load(16'(16'h0500 + i), 16'hDEAD);
      end
      push_copy(16'h0400, 16'h0500, 5);
      start_xfer(16'h0400, 16'h0500, 5, 1'b0);
      wc = 0;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         if (write) wc++;
         if (wc == 2) break;
      end
      chk("rm_second_write", wc, 2);
      #1;
      reset = 1'b1;
      #1;
      chk("rm_async", {hold, bus_grant, write, active}, 0);
      wq.delete();
      rdq.delete();
      dq.delete();
      @(negedge clk);
      reset = 1'b0;
      bad = 0;
      repeat (5) begin
         @(negedge clk);
         if (done || hold) bad++;
      end
      chk("rm_no_done", bad, 0);
      n = 0;
      for (int i = 0; i < 5; i++)
         if (ram[16'(16'h0500 + i)] !== 16'hDEAD) n++;
      chk("rm_words_1or2", (n >= 1 && n <= 2), 1);
      chk("rm_first", ram[16'h0500], ram[16'h0400]);

`ifdef DMA16_FILL_EN
      for (int i = 0; i < 3; i++) load(16'(16'h0300 + i), 16'h0);
      push_fill(16'hBEEF, 16'h0300, 3);
      start_xfer(16'hBEEF, 16'h0300, 3, 1'b1);
      wait_done();
      repeat (2) @(negedge clk);
      for (int i = 0; i < 3; i++)
         chk("fill_word", ram[16'(16'h0300 + i)], 16'hBEEF);
      end_checks();
`endif

      // random transfers, overlap and wrap allowed
      for (int t = 0; t < 20; t++) begin
         busy_delay = $urandom_range(0, 4);
         s = 16'($urandom);
         d = 16'($urandom);
         if (t % 4 == 0) d = s + 16'($urandom_range(1, 3));
         n = $urandom_range(1, 8);
         f = 1'b0;
`ifdef DMA16_FILL_EN
         f = ($urandom_range(0, 2) == 0);
`endif
         prep(s, d, n);
         if (f) push_fill(s, d, n);
         else push_copy(s, d, n);
         start_xfer(s, d, 16'(n), f);
         wait_done();
         repeat (2) @(negedge clk);
         check_mem(d, n);
         end_checks();
      end

      a = 16'h0;
      if (a != 16'h0) chk("unused", 1, 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
